// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: state encodings, default geometry and thresholds,
// and the mapping from occupancy to the steady (non-error) state.
package fifo_pkg;

  localparam int DEPTH_BITS_DEF = 3;
  localparam int AF_THRESH_DEF  = 6;
  localparam int AE_THRESH_DEF  = 2;

  typedef enum logic [1:0] {
    VACIO  = 2'b00,
    ACTIVO = 2'b01,
    LLENO  = 2'b10,
    ERROR  = 2'b11
  } estado_t;

  function automatic estado_t estado_de_ocupacion(input int unsigned ocup,
                                                  input int unsigned depth);
    if (ocup == 0)          return VACIO;
    else if (ocup == depth) return LLENO;
    else                    return ACTIVO;
  endfunction

endpackage

// File: rtl/contador_ptr.sv
// Wrapping W-bit pointer counter with enable and async active-high reset.
module contador_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // Natural overflow of the W-bit add provides the modulo-2**W wrap.
  always_comb cnt_d = en ? cnt_q + W'(1) : cnt_q;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of its inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/controlador_fifo.sv
// FIFO control: pointers, occupancy, flags, grants and sticky error FSM.
// Optional macro ERR_CLEAR_EN adds an err_clear input that releases ERROR.
module controlador_fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH_BITS = DEPTH_BITS_DEF,
  parameter int AF_THRESH  = AF_THRESH_DEF,
  parameter int AE_THRESH  = AE_THRESH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [DEPTH_BITS-1:0] wr_addr,
  output logic [DEPTH_BITS-1:0] rd_addr,
  output logic [DEPTH_BITS:0]   ocupacion,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error,
  output logic [1:0]            estado
`ifdef ERR_CLEAR_EN
  , input logic                 err_clear
`endif
);

  localparam int unsigned DEPTH = 2 ** DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] DEPTH_L = (DEPTH_BITS + 1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] AF_L    = (DEPTH_BITS + 1)'(AF_THRESH);
  localparam logic [DEPTH_BITS:0] AE_L    = (DEPTH_BITS + 1)'(AE_THRESH);

  logic [DEPTH_BITS:0] ocupacion_q, ocupacion_d;
  logic                error_q, error_d;
  estado_t             estado_q, estado_d;
  logic                violacion;

  assign full         = (ocupacion_q == DEPTH_L);
  assign empty        = (ocupacion_q == '0);
  assign almost_full  = (ocupacion_q >= AF_L);
  assign almost_empty = (ocupacion_q <= AE_L);

  // Grants look only at current flags: no same-cycle bypass at full/empty.
  assign wr_en     = push & ~full;
  assign rd_en     = pop & ~empty;
  assign violacion = (push & full) | (pop & empty);

  contador_ptr #(.W(DEPTH_BITS)) u_ptr_wr (
    .clk  (clk),
    .reset(reset),
    .en   (wr_en),
    .cnt  (wr_addr)
  );

  contador_ptr #(.W(DEPTH_BITS)) u_ptr_rd (
    .clk  (clk),
    .reset(reset),
    .en   (rd_en),
    .cnt  (rd_addr)
  );

  always_comb begin
    unique case ({wr_en, rd_en})
      2'b10:   ocupacion_d = ocupacion_q + 1'b1;
      2'b01:   ocupacion_d = ocupacion_q - 1'b1;
      default: ocupacion_d = ocupacion_q;
    endcase
  end

  // NOTE: defaults first, so every path assigns every output and no latch
  // is inferred.
  always_comb begin
    estado_d = estado_q;
    error_d  = error_q;
    if (violacion) begin
      error_d  = 1'b1;
      estado_d = ERROR;
    end else begin
      unique case (estado_q)
        VACIO:  if (wr_en) estado_d = ACTIVO;
        ACTIVO: begin
          if (ocupacion_d == DEPTH_L)  estado_d = LLENO;
          else if (ocupacion_d == '0)  estado_d = VACIO;
        end
        LLENO:  if (rd_en) estado_d = ACTIVO;
        ERROR: begin
`ifdef ERR_CLEAR_EN
          // Leave ERROR into the state matching the occupancy being stored.
          if (err_clear) estado_d = estado_de_ocupacion(int'(ocupacion_d), DEPTH);
`else
          estado_d = ERROR;
`endif
        end
        default: estado_d = ERROR;
      endcase
`ifdef ERR_CLEAR_EN
      if (err_clear) error_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ocupacion_q <= '0;
      error_q     <= 1'b0;
      estado_q    <= VACIO;
    end else begin
      ocupacion_q <= ocupacion_d;
      error_q     <= error_d;
      estado_q    <= estado_d;
    end
  end

  assign ocupacion = ocupacion_q;
  assign error     = error_q;
  assign estado    = estado_q;

endmodule

// File: tb/tb_controlador_fifo.sv
// Bench for controlador_fifo: queue-level occupancy model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_controlador_fifo;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       err_clear = 1'b0;
  logic       wr_en, rd_en;
  logic [2:0] wr_addr, rd_addr;
  logic [3:0] ocupacion;
  logic       full, empty, almost_full, almost_empty, error;
  logic [1:0] estado;

  int n_cmp  = 0;
  int n_fail = 0;

  controlador_fifo dut (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .pop         (pop),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .wr_addr     (wr_addr),
    .rd_addr     (rd_addr),
    .ocupacion   (ocupacion),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .error       (error),
    .estado      (estado)
`ifdef ERR_CLEAR_EN
    , .err_clear (err_clear)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: total entries written and read; everything else follows from them.
  int m_wr_tot = 0;
  int m_rd_tot = 0;
  bit m_err    = 0;

  function automatic int m_occ();
    return m_wr_tot - m_rd_tot;
  endfunction

  function automatic int m_estado();
    if (m_err)           return 3;
    if (m_occ() == 0)    return 0;
    if (m_occ() == 8)    return 2;
    return 1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_wr_tot = 0;
      m_rd_tot = 0;
      m_err    = 0;
    end else begin
      automatic int  occ  = m_occ();
      automatic bit  viol = (push && occ == 8) || (pop && occ == 0);
      if (push && occ < 8) m_wr_tot++;
      if (pop && occ > 0)  m_rd_tot++;
      if (viol) m_err = 1;
`ifdef ERR_CLEAR_EN
      else if (err_clear) m_err = 0;
`endif
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("wr_en",        wr_en,        int'(push && m_occ() < 8));
      check("rd_en",        rd_en,        int'(pop && m_occ() > 0));
      check("wr_addr",      wr_addr,      m_wr_tot % 8);
      check("rd_addr",      rd_addr,      m_rd_tot % 8);
      check("ocupacion",    ocupacion,    m_occ());
      check("full",         full,         int'(m_occ() == 8));
      check("empty",        empty,        int'(m_occ() == 0));
      check("almost_full",  almost_full,  int'(m_occ() >= 6));
      check("almost_empty", almost_empty, int'(m_occ() <= 2));
      check("error",        error,        int'(m_err));
      check("estado",       estado,       m_estado());
    end
  end

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic step(input bit p, input bit q, input int n = 1);
    for (int i = 0; i < n; i++) begin
      push = p;
      pop  = q;
      @(posedge clk);
      #1;
    end
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic do_reset();
    push = 1'b0;
    pop  = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_ocup"},    ocupacion, 0);
    check({tag, "_empty"},   empty, 1);
    check({tag, "_ae"},      almost_empty, 1);
    check({tag, "_full"},    full, 0);
    check({tag, "_af"},      almost_full, 0);
    check({tag, "_error"},   error, 0);
    check({tag, "_estado"},  estado, 0);
  endtask

  initial begin
    #12;
    check_reset_vals("rst");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: three pushes
    step(1, 0, 3);
    check("t1_wr_addr", wr_addr, 3);
    check("t1_ocup",    ocupacion, 3);
    check("t1_empty",   empty, 0);
    check("t1_ae",      almost_empty, 0);
    check("t1_estado",  estado, 1);
    check("t1_error",   error, 0);

    // 2: fill to 8, then overflow
    step(1, 0, 2);
    check("t2_af_at5", almost_full, 0);
    step(1, 0, 1);
    check("t2_af_at6", almost_full, 1);
    step(1, 0, 2);
    check("t2_full",    full, 1);
    check("t2_estado",  estado, 2);
    check("t2_wr_wrap", wr_addr, 0);
    push = 1'b1;
    #1 check("t2_wr_en_rej", wr_en, 0);
    @(posedge clk);
    #1 push = 1'b0;
    check("t2_error",  error, 1);
    check("t2_estado_err", estado, 3);
    check("t2_ocup",   ocupacion, 8);

    // 3: fill, drain, underflow
    do_reset();
    step(1, 0, 8);
    step(0, 1, 8);
    check("t3_rd_wrap", rd_addr, 0);
    check("t3_empty",   empty, 1);
    check("t3_estado",  estado, 0);
    check("t3_noerr",   error, 0);
    pop = 1'b1;
    #1 check("t3_rd_en_rej", rd_en, 0);
    @(posedge clk);
    #1 pop = 1'b0;
    check("t3_error", error, 1);

    // 4: simultaneous push/pop at occupancy 4
    do_reset();
    step(1, 0, 4);
    step(1, 1, 5);
    check("t4_ocup",    ocupacion, 4);
    check("t4_wr_addr", wr_addr, 1);
    check("t4_rd_addr", rd_addr, 5);

    // 5a: push+pop on empty
    do_reset();
    push = 1'b1;
    pop  = 1'b1;
    #1;
    check("t5a_wr_en", wr_en, 1);
    check("t5a_rd_en", rd_en, 0);
    @(posedge clk);
    #1 push = 1'b0;
    pop = 1'b0;
    check("t5a_ocup",  ocupacion, 1);
    check("t5a_error", error, 1);

    // 5b: push+pop on full
    do_reset();
    step(1, 0, 8);
    push = 1'b1;
    pop  = 1'b1;
    #1;
    check("t5b_wr_en", wr_en, 0);
    check("t5b_rd_en", rd_en, 1);
    @(posedge clk);
    #1 push = 1'b0;
    pop = 1'b0;
    check("t5b_ocup",  ocupacion, 7);
    check("t5b_error", error, 1);

    // 6: asynchronous reset between edges at occupancy 5
    do_reset();
    step(1, 0, 5);
    check("t6_ocup_pre", ocupacion, 5);
    push = 1'b1;
    #2 reset = 1'b1;
    #1 check_reset_vals("t6");
    #3 reset = 1'b0;
    push = 1'b0;
    @(posedge clk);
    #1 check("t6_after_ocup", ocupacion, 0);

`ifdef ERR_CLEAR_EN
    // 6b: clear an error at occupancy 2
    do_reset();
    step(0, 1, 1);
    step(1, 0, 2);
    check("t6b_error_set", error, 1);
    err_clear = 1'b1;
    @(posedge clk);
    #1 err_clear = 1'b0;
    check("t6b_error_clr", error, 0);
    check("t6b_estado",    estado, 1);
    check("t6b_ocup",      ocupacion, 2);
`endif

    step(0, 0, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
